// File: rtl/pmem_dpi_port_if.sv
`default_nettype none
// ==========================================================================
// Module  : pmem_dpi_port_if
// Brief   : request/response channel between a requester and pmem_dpi_port
// Rev     : 1.0
// ==========================================================================
interface pmem_dpi_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic                      req_wen;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_wmask;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/pmem_dpi_port.sv
`default_nettype none
// ==========================================================================
// Module  : pmem_dpi_port
// Brief   : valid/ready memory port with programmable latency, backed by
//           pmem_read/pmem_write. PMEM_MISALIGN_CHECK_EN flags misaligned
//           accesses.
// Rev     : 1.0
// ==========================================================================
module pmem_dpi_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  wire             clock,
  input  wire             reset,
  pmem_dpi_port_if.slave  bus
);

  localparam int C_BYTES = DATA_WIDTH / 8;
  localparam int C_WORDS = DATA_WIDTH / 32;
  localparam int C_OFFS  = $clog2(C_BYTES);

  // Stand-in for the C model: sparse word store plus call counters.
  int sim_mem [int];
  int dpi_rd_calls;
  int dpi_wr_calls;

  function automatic void pmem_read(input int raddr, output int rdata);
    dpi_rd_calls = dpi_rd_calls + 1;
    rdata = sim_mem.exists(raddr) ? sim_mem[raddr] : 0;
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata);
    dpi_wr_calls = dpi_wr_calls + 1;
    sim_mem[waddr] = wdata;
  endfunction

  // Word-sliced access; writes read-merge-write only words with enabled bytes.
  function automatic logic [DATA_WIDTH-1:0] do_access(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  wen,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [C_BYTES-1:0]    wm
  );
    logic [DATA_WIDTH-1:0] rd;
    logic [31:0]           base;
    int                    word_old;
    logic [31:0]           word_new;
    rd   = '0;
    base = (32'(a) >> C_OFFS) << C_OFFS;
    for (int k = 0; k < C_WORDS; k++) begin
      if (!wen) begin
        pmem_read(int'(base + 32'(4 * k)), word_old);
        rd[32*k +: 32] = word_old;
      end else if (wm[4*k +: 4] != 4'h0) begin
        pmem_read(int'(base + 32'(4 * k)), word_old);
        word_new = word_old;
        for (int b = 0; b < 4; b++) begin
          if (wm[4*k + b]) begin
            word_new[8*b +: 8] = wd[32*k + 8*b +: 8];
          end
        end
        pmem_write(int'(base + 32'(4 * k)), int'(word_new));
      end
    end
    return rd;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wen_q, wen_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [C_BYTES-1:0]     wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   access;

`ifdef PMEM_MISALIGN_CHECK_EN
  logic                   err_q;
  logic                   misaligned;
  assign misaligned     = |addr_q[C_OFFS-1:0];
  assign bus.resp_err   = err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

  assign bus.req_ready  = reset & (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wen_d   = bus.req_wen;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data comes straight from the model calls, so it is captured here
  // on the access edge instead of through a combinational _d path.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
`ifdef PMEM_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      if (access) begin
`ifdef PMEM_MISALIGN_CHECK_EN
        if (misaligned) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          rdata_q <= do_access(addr_q, wen_q, wdata_q, wmask_q);
          err_q   <= 1'b0;
        end
`else
        rdata_q <= do_access(addr_q, wen_q, wdata_q, wmask_q);
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmem_dpi_port.sv
`default_nettype none
// ==========================================================================
// Module  : tb_pmem_dpi_port
// Brief   : bench for pmem_dpi_port: instance A (32-bit, latency 3) and
//           instance B (64-bit, latency 4) against a byte-level memory model
// Rev     : 1.0
// ==========================================================================
module tb_pmem_dpi_port;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pmem_dpi_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
  pmem_dpi_port_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus_b ();

  pmem_dpi_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LATENCY(3)) dut_a (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_a.slave)
  );

  pmem_dpi_port #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .LATENCY(4)) dut_b (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_b.slave)
  );

  // Index 0 drives instance A, index 1 drives instance B.
  logic        t_valid  [2];
  logic [31:0] t_addr   [2];
  logic        t_wen    [2];
  logic [63:0] t_wdata  [2];
  logic [7:0]  t_wmask  [2];
  logic        t_rready [2];

  assign bus_a.req_valid  = t_valid[0];
  assign bus_a.req_addr   = t_addr[0];
  assign bus_a.req_wen    = t_wen[0];
  assign bus_a.req_wdata  = t_wdata[0][31:0];
  assign bus_a.req_wmask  = t_wmask[0][3:0];
  assign bus_a.resp_ready = t_rready[0];
  assign bus_b.req_valid  = t_valid[1];
  assign bus_b.req_addr   = t_addr[1];
  assign bus_b.req_wen    = t_wen[1];
  assign bus_b.req_wdata  = t_wdata[1];
  assign bus_b.req_wmask  = t_wmask[1];
  assign bus_b.resp_ready = t_rready[1];

  logic [1:0]  o_req_ready, o_resp_valid, o_resp_err;
  logic [63:0] o_rdata [2];
  assign o_req_ready  = {bus_b.req_ready,  bus_a.req_ready};
  assign o_resp_valid = {bus_b.resp_valid, bus_a.resp_valid};
  assign o_resp_err   = {bus_b.resp_err,   bus_a.resp_err};
  assign o_rdata[0]   = {32'h0, bus_a.resp_rdata};
  assign o_rdata[1]   = bus_b.resp_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference memory: bytes keyed by {instance, byte address}.
  byte unsigned mem_m [bit [32:0]];

  function automatic void model_access(input int inst, input logic [31:0] addr, input logic wen,
                                       input logic [63:0] wd, input logic [7:0] wm,
                                       output logic [63:0] rd, output logic er, output int nwr);
    int unsigned nb;
    logic [31:0] aligned;
    bit   [32:0] key;
    nb      = (inst == 0) ? 4 : 8;
    aligned = addr - (addr % nb);
    rd = '0; er = 1'b0; nwr = 0;
`ifdef PMEM_MISALIGN_CHECK_EN
    if (addr % nb != 0) begin
      er = 1'b1;
      return;
    end
`endif
    for (int i = 0; i < int'(nb); i++) begin
      key = {inst[0], aligned + 32'(i)};
      if (!wen) rd[8*i +: 8] = mem_m.exists(key) ? mem_m[key] : 8'h00;
      else if (wm[i]) mem_m[key] = wd[8*i +: 8];
    end
    if (wen) begin
      for (int k = 0; k < int'(nb) / 4; k++) if (wm[4*k +: 4] != 4'h0) nwr++;
    end
  endfunction

  function automatic int wr_calls(input int inst);
    return (inst == 0) ? dut_a.dpi_wr_calls : dut_b.dpi_wr_calls;
  endfunction

  function automatic int rd_calls(input int inst);
    return (inst == 0) ? dut_a.dpi_rd_calls : dut_b.dpi_rd_calls;
  endfunction

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic xact(input int inst, input logic [31:0] addr, input logic wen,
                      input logic [63:0] wd, input logic [7:0] wm,
                      output logic [63:0] rd, output logic er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = -1;
    t_valid[inst] = 1'b1; t_addr[inst] = addr; t_wen[inst] = wen;
    t_wdata[inst] = wd;   t_wmask[inst] = wm;  t_rready[inst] = 1'b1;
    n = 0;
    while (!o_req_ready[inst] && n < 50) begin @(negedge clk); n++; end
    if (!o_req_ready[inst]) begin t_valid[inst] = 1'b0; return; end
    @(negedge clk);
    t_valid[inst] = 1'b0;
    n = 1;
    while (!o_resp_valid[inst] && n < 40) begin @(negedge clk); n++; end
    if (!o_resp_valid[inst]) return;
    lat = n; rd = o_rdata[inst]; er = o_resp_err[inst];
    @(negedge clk);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t        vecs [10];
  logic [63:0] g_rd, m_rd, hold;
  logic        g_er, m_er, seen;
  int          g_lat, m_nw, wc0, n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 32'h8000_0000, 1'b1, 64'h0000_0000_1234_5678, 8'h0F, 64'h0};
    vecs[1] = '{0, 32'h8000_0004, 1'b1, 64'h0000_0000_CAFE_F00D, 8'h0F, 64'h0};
    vecs[2] = '{1, 32'h8000_0010, 1'b1, 64'h1111_1111_2222_2222, 8'hFF, 64'h0};
    vecs[3] = '{1, 32'h8000_0020, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0};
    vecs[4] = '{0, 32'h8000_0000, 1'b0, 64'h0,                   8'h00, 64'h1234_5678};
    vecs[5] = '{0, 32'h8000_0004, 1'b1, 64'h0000_0000_0000_00AA, 8'h01, 64'h0};
    vecs[6] = '{0, 32'h8000_0004, 1'b0, 64'h0,                   8'h00, 64'hCAFE_F0AA};
    vecs[7] = '{1, 32'h8000_0010, 1'b0, 64'h0,                   8'h00, 64'h1111_1111_2222_2222};
    vecs[8] = '{1, 32'h8000_0018, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0};
    vecs[9] = '{1, 32'h8000_0018, 1'b0, 64'h0,                   8'h00, 64'h0};

    for (int i = 0; i < 2; i++) begin
      t_valid[i] = 1'b1; t_addr[i] = 32'h8000_0000; t_wen[i] = 1'b1;
      t_wdata[i] = '1;   t_wmask[i] = '1;           t_rready[i] = 1'b1;
    end

    // Reset held with requests pending.
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rst_req_ready%0d_c%0d", i, c), o_req_ready[i], 1'b0);
        check($sformatf("rst_resp_valid%0d_c%0d", i, c), o_resp_valid[i], 1'b0);
      end
    end
    check("rst_rdata_a", o_rdata[0], 64'h0);
    check("rst_err_b", o_resp_err[1], 1'b0);
    check("rst_dpi_calls", rd_calls(0) + wr_calls(0) + rd_calls(1) + wr_calls(1), 0);
    rst_n = 1'b1; t_valid[0] = 1'b0; t_valid[1] = 1'b0;
    @(negedge clk);
    check("rst_release_ready_a", o_req_ready[0], 1'b1);
    check("rst_release_ready_b", o_req_ready[1], 1'b1);

    // Table vectors.
    foreach (vecs[i]) begin
      model_access(vecs[i].inst, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, m_rd, m_er, m_nw);
      xact(vecs[i].inst, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, g_rd, g_er, g_lat);
      check($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), g_er, 1'b0);
      check($sformatf("vec%0d_lat", i), g_lat, (vecs[i].inst == 0) ? 4 : 5);
    end

    // Latency-3 read: valid in cycle 4, ready again in cycle 5.
    xact(0, 32'h8000_0000, 1'b0, 64'h0, 8'h0, g_rd, g_er, g_lat);
    check("lat3_cycle", g_lat, 4);
    check("lat3_rdata", g_rd, 64'h1234_5678);
    check("lat3_err", g_er, 1'b0);
    check("lat3_ready_c5", o_req_ready[0], 1'b1);

    // Masked 64-bit write touches only the lower word.
    wc0 = wr_calls(1);
    model_access(1, 32'h8000_0010, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0C, m_rd, m_er, m_nw);
    xact(1, 32'h8000_0010, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0C, g_rd, g_er, g_lat);
    check("mwr_rdata", g_rd, 64'h0);
    check("mwr_write_calls", wr_calls(1) - wc0, 1);
    xact(1, 32'h8000_0010, 1'b0, 64'h0, 8'h0, g_rd, g_er, g_lat);
    check("mwr_readback", g_rd, 64'h1111_1111_BBBB_2222);
    wc0 = wr_calls(1);
    xact(1, 32'h8000_0010, 1'b1, 64'h0, 8'h00, g_rd, g_er, g_lat);
    check("zmask_write_calls", wr_calls(1) - wc0, 0);
    check("zmask_lat", g_lat, 5);

    // Response backpressure with a second request waiting.
    t_valid[0] = 1'b1; t_addr[0] = 32'h8000_0000; t_wen[0] = 1'b0; t_rready[0] = 1'b0;
    @(negedge clk);
    t_addr[0] = 32'h8000_0004;
    n = 1;
    while (!o_resp_valid[0] && n < 40) begin @(negedge clk); n++; end
    check("bp_first_lat", n, 4);
    hold = o_rdata[0];
    check("bp_first_rdata", hold, 64'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c), o_resp_valid[0], 1'b1);
      check($sformatf("bp_rdata_c%0d", c), o_rdata[0], 64'h1234_5678);
      check($sformatf("bp_ready_c%0d", c), o_req_ready[0], 1'b0);
    end
    t_rready[0] = 1'b1;
    @(negedge clk);
    check("bp_after_valid", o_resp_valid[0], 1'b0);
    check("bp_after_ready", o_req_ready[0], 1'b1);
    @(negedge clk);
    t_valid[0] = 1'b0;
    model_access(0, 32'h8000_0004, 1'b0, 64'h0, 8'h0, m_rd, m_er, m_nw);
    n = 1;
    while (!o_resp_valid[0] && n < 40) begin @(negedge clk); n++; end
    check("bp_second_lat", n, 4);
    check("bp_second_rdata", o_rdata[0], m_rd);
    @(negedge clk);

    // Reset while instance B is BUSY abandons the write.
    wc0 = wr_calls(1);
    t_valid[1] = 1'b1; t_addr[1] = 32'h8000_0020; t_wen[1] = 1'b1;
    t_wdata[1] = 64'hDEAD_BEEF_DEAD_BEEF; t_wmask[1] = 8'hFF; t_rready[1] = 1'b1;
    @(negedge clk);
    t_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); seen = seen | o_resp_valid[1]; end
    check("rbusy_no_resp", seen, 1'b0);
    check("rbusy_write_calls", wr_calls(1) - wc0, 0);
    xact(1, 32'h8000_0020, 1'b0, 64'h0, 8'h0, g_rd, g_er, g_lat);
    check("rbusy_mem_unchanged", g_rd, 64'h0123_4567_89AB_CDEF);

    // Misaligned read.
    xact(0, 32'h8000_0002, 1'b0, 64'h0, 8'h0, g_rd, g_er, g_lat);
`ifdef PMEM_MISALIGN_CHECK_EN
    check("misalign_rdata", g_rd, 64'h0);
    check("misalign_err", g_er, 1'b1);
`else
    check("misalign_rdata", g_rd, 64'h1234_5678);
    check("misalign_err", g_er, 1'b0);
`endif
    check("misalign_lat", g_lat, 4);

    // Random traffic against the byte model.
    for (int r = 0; r < 40; r++) begin
      int          inst;
      logic [31:0] addr;
      logic        wen;
      logic [63:0] wd;
      logic [7:0]  wm;
      inst = int'($urandom_range(0, 1));
      addr = 32'h8000_0000 + 32'($urandom_range(0, 63));
      wen  = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      wm   = 8'($urandom_range(0, 255));
      if (inst == 0) wm[7:4] = 4'h0;
      wc0 = wr_calls(inst);
      model_access(inst, addr, wen, wd, wm, m_rd, m_er, m_nw);
      xact(inst, addr, wen, wd, wm, g_rd, g_er, g_lat);
      check($sformatf("rnd%0d_rdata", r), g_rd, m_rd);
      check($sformatf("rnd%0d_err", r), g_er, m_er);
      check($sformatf("rnd%0d_lat", r), g_lat, (inst == 0) ? 4 : 5);
      check($sformatf("rnd%0d_write_calls", r), wr_calls(inst) - wc0, m_nw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmem_dpi_port.md
# pmem_dpi_port

Parametrised simulation-only memory port for the npc core. It replaces the old combinational, always-valid DPI memory stub with a valid/ready request/response channel, a programmable access latency, a byte write mask and 32- or 64-bit data. It is backed by the C-side physical memory model through the DPI-C functions `pmem_read(int raddr, output int rdata)` and `pmem_write(int waddr, int wdata)`. It sits between the core's LSU/IFU memory interface and the C-side model, and allows one outstanding transaction.

## Interface
- DATA_WIDTH, 32: data width; legal values are 32 and 64.
- ADDR_WIDTH, 32: byte address width; legal range is ≤ 32.
- LATENCY, 1: number of BUSY cycles before the access; legal range is 1..15.
- clock  in  1  single clock; all state changes on the posedge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  port can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- resp_err  out  1  error flag; only ever set with PMEM_MISALIGN_CHECK_EN.

## Operation
- **States:** IDLE, BUSY, RESP; plus a 4-bit latency counter `cnt`.
- **IDLE**
  - req_ready = 1.
  - On req_valid & req_ready: latch addr, wen, wdata and wmask; set cnt = LATENCY-1; go to BUSY.
- **BUSY**
  - req_ready = 0.
  - Each edge with cnt ≠ 0: decrement cnt.
  - Edge with cnt == 0: perform the DPI access, register the results, go to RESP.
- **DPI access**
  - The latched address is aligned down to DATA_WIDTH/8 bytes.
  - The access is handled as N = DATA_WIDTH/32 words at addresses A + 4k, where word k maps to data bits [32k+31:32k].
  - Read: `pmem_read` is called for every word; resp_rdata is the concatenation.
  - Write, per word:
    - If any of its 4 mask bits is set: `pmem_read` the word, merge the enabled bytes from wdata, then `pmem_write` the merged word.
    - Words whose mask bits are all 0 get no DPI call.
    - An all-zero wmask therefore touches no memory but still produces a response.
  - DPI calls occur only on that single clock edge, never in combinational logic.
- **RESP**
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE.
- **Handshake rules**
  - The requester must hold req_* stable while req_valid & !req_ready.
  - Requests presented outside IDLE are not sampled.
  - There is no response bypass: a request cannot be accepted in the same cycle as a response handshake.

## Timing
- **Latency:** cycle 0 is the request handshake cycle. resp_valid is first high in cycle LATENCY+1 (LATENCY=1 gives cycle 2).
- **Throughput:** with resp_ready held high, one transaction every LATENCY+2 cycles.
- **Reset (reset = 0 sampled at an edge):**
  - state = IDLE, cnt = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - req_ready is forced to 0 while reset is low; it is 1 in the first cycle after release.
- **Reset mid-operation:**
  - In BUSY: the transaction is abandoned and no DPI access occurs.
  - In RESP: the response is dropped.
- **resp_ready with no response:** resp_ready high while resp_valid is low has no effect.

## Configuration
- PMEM_MISALIGN_CHECK_EN
  - Defined: at the access edge, if addr[log2(DATA_WIDTH/8)-1:0] ≠ 0, no DPI call is made, resp_rdata = 0 and resp_err = 1. Timing is unchanged.
  - Undefined: the low address bits are silently ignored (address aligned down) and resp_err is tied to 0.

## Test plan
- **Reset:** hold reset = 0 for 3 cycles with req_valid = 1 → req_ready = 0 and resp_valid = 0 throughout; no DPI calls; req_ready = 1 on the first cycle after release.
- **Latency-3 read:** LATENCY=3, DW=32, model word at 0x80000000 = 0x12345678, read 0x80000000, resp_ready = 1 → resp_valid rises in cycle 4, resp_rdata = 0x12345678, resp_err = 0, req_ready high again in cycle 5.
- **Masked write:** DW=64, memory 0x80000010..17 = 0x1111111122222222, write wdata 0xAAAAAAAABBBBBBBB, wmask 0x0C → memory reads back 0x11111111BBBB2222; exactly one `pmem_write` call, at 0x80000010.
- **Response backpressure:** hold resp_ready = 0 for 5 cycles → resp_valid and resp_rdata are stable throughout; req_ready = 0 throughout; a second req_valid is not accepted until the cycle after the response handshake.
- **Reset in BUSY:** LATENCY=4, write to 0x80000020, assert reset in cycle 2 → memory is unchanged and no response appears.
- **Misaligned read:** read 0x80000002, DW=32 → with PMEM_MISALIGN_CHECK_EN: resp_err = 1, resp_rdata = 0; without it: resp_rdata = word at 0x80000000, resp_err = 0.
